// File: rtl/mollusc_pkg.sv
// Shared definitions for the issue stage: slot state encoding and register-file geometry.
package mollusc_pkg;
  localparam int          NUM_REGS = 16;
  localparam logic [3:0]  REG_ZERO = 4'h0;
  localparam int          INSTR_W  = 27;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    JWAIT = 2'd2
  } issue_state_e;
endpackage

// File: rtl/issue_scoreboard.sv
// Pending-load register scoreboard: one bit per architectural register, r0 never pending.
module issue_scoreboard
  import mollusc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_valid,
  input  logic [3:0] set_idx,
  input  logic       clr_valid,
  input  logic [3:0] clr_idx,
  input  logic [3:0] lk_a,
  input  logic [3:0] lk_b,
  input  logic [3:0] lk_m,
  input  logic [3:0] lk_d,
  output logic       busy_a,
  output logic       busy_b,
  output logic       busy_m,
  output logic       busy_d
);
  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        // Set is OR'd after the clear so a same-cycle set and clear leaves the bit set.
        assign pending_next[gi] = (set_valid & (set_idx == 4'(gi))) |
                                  (pending_reg[gi] & ~(clr_valid & (clr_idx == 4'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_reg <= '0;
    else        pending_reg <= pending_next;
  end

  assign busy_a = (lk_a != REG_ZERO) & pending_reg[lk_a];
  assign busy_b = (lk_b != REG_ZERO) & pending_reg[lk_b];
  assign busy_m = (lk_m != REG_ZERO) & pending_reg[lk_m];
  assign busy_d = (lk_d != REG_ZERO) & pending_reg[lk_d];
endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue slot gating fetch into execute on load hazards, load credits and jumps.
// Optional stall counters (hazard_cycles, jump_cycles) are built when ISSUE_STALL_CNT_EN is defined.
module issue_ctrl
  import mollusc_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               if_ready,
  output logic [INSTR_W-1:0] slot_instr,
  input  logic [3:0]         dec_ra_a,
  input  logic [3:0]         dec_ra_b,
  input  logic [3:0]         dec_ra_m,
  input  logic [3:0]         dec_ra_d,
  input  logic               dec_is_mem,
  input  logic               dec_mem_write,
  input  logic               dec_is_jump,
  output logic               iss_valid,
  input  logic               iss_ready,
  input  logic               wb_valid,
  input  logic [3:0]         wb_rd,
  input  logic               redirect_valid,
  output logic               stall_hazard
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   hazard_cycles,
  output logic [CNT_W-1:0]   jump_cycles
`endif
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_LOADS);

  issue_state_e       state_reg;
  logic [INSTR_W-1:0] slot_reg;
  logic [3:0]         load_cnt_reg;
  logic               busy_a, busy_b, busy_m, busy_d;
  logic               hazard, is_load, nocredit, full, fire, load_fire;

  issue_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (load_fire),
    .set_idx   (dec_ra_d),
    .clr_valid (wb_valid),
    .clr_idx   (wb_rd),
    .lk_a      (dec_ra_a),
    .lk_b      (dec_ra_b),
    .lk_m      (dec_ra_m),
    .lk_d      (dec_ra_d),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_m    (busy_m),
    .busy_d    (busy_d)
  );

  assign full         = (state_reg == FULL);
  assign hazard       = busy_a | busy_b | busy_m | busy_d;
  assign is_load      = dec_is_mem & ~dec_mem_write;
  assign nocredit     = is_load & (load_cnt_reg == MAX_CNT);
  assign iss_valid    = full & ~hazard & ~nocredit & ~redirect_valid;
  assign fire         = iss_valid & iss_ready;
  assign load_fire    = fire & is_load;
  assign if_ready     = (state_reg == EMPTY) | (full & fire & ~dec_is_jump);
  assign stall_hazard = full & (hazard | nocredit);
  assign slot_instr   = slot_reg;

  // Redirect takes priority over everything: it flushes the slot whatever the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      slot_reg  <= '0;
    end else if (redirect_valid) begin
      state_reg <= EMPTY;
      slot_reg  <= '0;
    end else begin
      case (state_reg)
        EMPTY: if (if_valid) begin
          state_reg <= FULL;
          slot_reg  <= if_instr;
        end
        FULL: if (fire) begin
          if (dec_is_jump) begin
            state_reg <= JWAIT;
            slot_reg  <= '0;
          end else if (if_valid) begin
            slot_reg  <= if_instr;
          end else begin
            state_reg <= EMPTY;
            slot_reg  <= '0;
          end
        end
        JWAIT:   state_reg <= JWAIT;
        default: state_reg <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_reg <= '0;
    end else if (load_fire && !wb_valid) begin
      load_cnt_reg <= load_cnt_reg + 4'd1;
    end else if (wb_valid && !load_fire && (load_cnt_reg != 4'd0)) begin
      load_cnt_reg <= load_cnt_reg - 4'd1;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cycles <= '0;
      jump_cycles   <= '0;
    end else begin
      if (stall_hazard && (hazard_cycles != '1)) hazard_cycles <= hazard_cycles + 1'b1;
      if ((state_reg == JWAIT) && (jump_cycles != '1)) jump_cycles <= jump_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed and randomized bench for issue_ctrl with the bench acting as the decoder.
module tb_issue_ctrl;
  localparam int MAX_LOADS = 4;
  localparam int CNT_W     = 32;
  localparam int S_EMPTY = 0, S_FULL = 1, S_JWAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, iss_ready, wb_valid, redirect_valid;
  logic [26:0] if_instr, slot_instr;
  logic [3:0]  wb_rd;
  logic        if_ready, iss_valid, stall_hazard;
  logic [3:0]  dec_ra_a, dec_ra_b, dec_ra_m, dec_ra_d;
  logic        dec_is_mem, dec_mem_write, dec_is_jump;
`ifdef ISSUE_STALL_CNT_EN
  logic [CNT_W-1:0] hazard_cycles, jump_cycles;
`endif

  // Instruction format used by this bench's decoder:
  // [3:0] ra_a, [7:4] ra_b, [11:8] ra_m, [15:12] ra_d, [16] mem, [17] write, [18] jump, [26:19] tag
  assign dec_ra_a      = slot_instr[3:0];
  assign dec_ra_b      = slot_instr[7:4];
  assign dec_ra_m      = slot_instr[11:8];
  assign dec_ra_d      = slot_instr[15:12];
  assign dec_is_mem    = slot_instr[16];
  assign dec_mem_write = slot_instr[17];
  assign dec_is_jump   = slot_instr[18];

  always #5 clk = ~clk;

  issue_ctrl #(.MAX_LOADS(MAX_LOADS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready), .slot_instr(slot_instr),
    .dec_ra_a(dec_ra_a), .dec_ra_b(dec_ra_b), .dec_ra_m(dec_ra_m), .dec_ra_d(dec_ra_d),
    .dec_is_mem(dec_is_mem), .dec_mem_write(dec_mem_write), .dec_is_jump(dec_is_jump),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect_valid(redirect_valid),
    .stall_hazard(stall_hazard)
`ifdef ISSUE_STALL_CNT_EN
    , .hazard_cycles(hazard_cycles), .jump_cycles(jump_cycles)
`endif
  );

  int          compared = 0;
  int          mismatched = 0;
  int          m_state;
  logic [26:0] m_slot;
  bit          m_pend [16];
  int          m_cnt;
  int          cyc = 0;

  function automatic logic [26:0] mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                                     input logic [3:0] d, input bit mem, input bit wr, input bit jmp);
    logic [7:0] tag;
    tag = 8'($urandom);
    return {tag, jmp, wr, mem, d, m, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_EMPTY;
    m_slot  = '0;
    m_cnt   = 0;
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".iss_valid"}, {31'd0, iss_valid}, 32'd0);
    chk({tag, ".if_ready"}, {31'd0, if_ready}, 32'd1);
    chk({tag, ".stall_hazard"}, {31'd0, stall_hazard}, 32'd0);
    chk({tag, ".slot_instr"}, {5'd0, slot_instr}, 32'd0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit ifv, input logic [26:0] ins, input bit issr,
                       input bit wbv, input logic [3:0] wbrd, input bit redir);
    logic [3:0] a, b, m, d;
    bit mem, wr, jmp, ld, haz, nocr, e_iv, e_fire, e_ifr, e_sh;
    @(negedge clk);
    if_valid = ifv; if_instr = ins; iss_ready = issr;
    wb_valid = wbv; wb_rd = wbrd; redirect_valid = redir;
    #2;
    a = m_slot[3:0]; b = m_slot[7:4]; m = m_slot[11:8]; d = m_slot[15:12];
    mem = m_slot[16]; wr = m_slot[17]; jmp = m_slot[18];
    haz  = (a != 0 && m_pend[a]) || (b != 0 && m_pend[b]) ||
           (m != 0 && m_pend[m]) || (d != 0 && m_pend[d]);
    ld   = mem && !wr;
    nocr = ld && (m_cnt == MAX_LOADS);
    e_iv   = (m_state == S_FULL) && !haz && !nocr && !redir;
    e_fire = e_iv && issr;
    e_ifr  = (m_state == S_EMPTY) || ((m_state == S_FULL) && e_fire && !jmp);
    e_sh   = (m_state == S_FULL) && (haz || nocr);
    chk("iss_valid", {31'd0, iss_valid}, {31'd0, e_iv});
    chk("if_ready", {31'd0, if_ready}, {31'd0, e_ifr});
    chk("stall_hazard", {31'd0, stall_hazard}, {31'd0, e_sh});
    chk("slot_instr", {5'd0, slot_instr}, {5'd0, m_slot});
    $display("cyc %0d st=%0d slot=%07h iv=%0d fire=%0d ifr=%0d sh=%0d cnt=%0d", cyc, m_state, m_slot,
             e_iv, e_fire, e_ifr, e_sh, m_cnt);
    @(posedge clk);
    cyc++;
    if (wbv && wbrd != 0) m_pend[wbrd] = 1'b0;
    if (e_fire && ld && d != 0) m_pend[d] = 1'b1;
    if (e_fire && ld && !wbv) m_cnt++;
    else if (wbv && !(e_fire && ld) && m_cnt > 0) m_cnt--;
    if (redir) begin
      m_state = S_EMPTY; m_slot = '0;
    end else if (m_state == S_EMPTY) begin
      if (ifv) begin m_state = S_FULL; m_slot = ins; end
    end else if (m_state == S_FULL && e_fire) begin
      if (jmp) begin m_state = S_JWAIT; m_slot = '0; end
      else if (ifv) m_slot = ins;
      else begin m_state = S_EMPTY; m_slot = '0; end
    end
  endtask

  initial begin
    int pend_list[$];
    logic [3:0] r;
    rst_n = 1'b0;
    if_valid = 0; if_instr = '0; iss_ready = 0; wb_valid = 0; wb_rd = '0; redirect_valid = 0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU ops: one fire per cycle.
    for (int i = 0; i < 5; i++) cycle(1, mk(3, 4, 0, 5, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Load r5 followed by a consumer of r5.
    cycle(1, mk(0, 0, 0, 5, 1, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(5, 0, 0, 6, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 5, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Credit limit: four loads, fifth blocked until a writeback.
    for (int i = 1; i <= 4; i++) cycle(1, mk(0, 0, 0, 4'(i), 1, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(0, 0, 0, 6, 1, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 1, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(1, mk(0, 0, 0, 8, 1, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    for (int i = 2; i <= 4; i++) cycle(0, '0, 1, 1, 4'(i), 0);
    cycle(0, '0, 1, 1, 6, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Jump: JWAIT ignores fetch until redirect.
    cycle(1, mk(1, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0);
    cycle(1, mk(2, 0, 0, 3, 0, 0, 0), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, mk(2, 0, 0, 3, 0, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(2, 0, 0, 3, 0, 0, 0), 1, 0, 0, 1);
    cycle(1, mk(2, 0, 0, 3, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Load r7 fires while a writeback to r7 completes: bit stays set, count unchanged.
    cycle(1, mk(0, 0, 0, 1, 1, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(0, 0, 0, 7, 1, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(7, 0, 0, 9, 0, 0, 0), 1, 1, 7, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 7, 0);
    cycle(0, '0, 1, 1, 1, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // Redirect overrides a ready fire in FULL.
    cycle(1, mk(3, 0, 0, 4, 0, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(3, 0, 0, 4, 0, 0, 0), 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 0);

    // Reset asserted mid-stall.
    cycle(1, mk(0, 0, 0, 2, 1, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(2, 0, 0, 3, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    if_valid = 0; iss_ready = 0; wb_valid = 0; redirect_valid = 0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit ifv, issr, wbv, redir, mem, wr, jmp;
      logic [3:0] wr_idx;
      ifv   = ($urandom_range(0, 9) < 7);
      issr  = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      mem   = ($urandom_range(0, 9) < 4);
      wr    = mem && ($urandom_range(0, 2) == 0);
      jmp   = !mem && ($urandom_range(0, 9) == 0);
      pend_list.delete();
      for (int k = 1; k < 16; k++) if (m_pend[k]) pend_list.push_back(k);
      wbv = 0; wr_idx = '0;
      if ($urandom_range(0, 2) == 0) begin
        wbv = 1;
        if (pend_list.size() > 0 && $urandom_range(0, 4) != 0)
          wr_idx = 4'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
        else
          wr_idx = 4'($urandom_range(0, 15));
      end
      r = 4'($urandom_range(0, 7));
      cycle(ifv, mk(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'd0, r, mem, wr, jmp),
            issr, wbv, wr_idx, redir);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Single-entry issue controller between instruction fetch and the combinational decoder.
- Holds one 27-bit instruction in a slot and presents it to the decoder, which returns register addresses and op-class flags.
- Gates issue into execute using a 16-entry register scoreboard for outstanding loads, a load-credit counter, and a jump-wait state.

Parameters:
- MAX_LOADS, 4, maximum loads issued but not yet written back (1..15).
- CNT_W, 32, width of the optional stall counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  27  fetched instruction word.
- if_ready  out  1  slot accepts if_instr this cycle.
- slot_instr  out  27  held instruction, driven to the decoder.
- dec_ra_a, dec_ra_b, dec_ra_m, dec_ra_d  in  4 each  decoded register addresses; 0 means unused.
- dec_is_mem  in  1  decoded memory op.
- dec_mem_write  in  1  decoded store.
- dec_is_jump  in  1  decoded jump.
- iss_valid  out  1  slot instruction is issuable.
- iss_ready  in  1  execute accepts.
- wb_valid  in  1  load writeback completes.
- wb_rd  in  4  destination of the completing load.
- redirect_valid  in  1  jump resolved or trap; flush the slot.
- stall_hazard  out  1  slot is full but blocked by scoreboard or credits.

Behaviour:
- Reset values: state EMPTY, slot_instr 0, scoreboard 0, load_cnt 0, iss_valid 0, stall_hazard 0, if_ready 1.
- States: EMPTY (slot empty), FULL (slot holds an instruction), JWAIT (jump issued, awaiting redirect).
- Definitions:
  - load = dec_is_mem & ~dec_mem_write.
  - hazard = any of ra_a, ra_b, ra_m, ra_d nonzero with its scoreboard bit set (RAW and WAW).
  - nocredit = load & (load_cnt == MAX_LOADS).
- iss_valid = (state==FULL) & ~hazard & ~nocredit & ~redirect_valid.
- fire = iss_valid & iss_ready.
- if_ready = (state==EMPTY) | (state==FULL & fire & ~dec_is_jump). It is combinational and 0 in JWAIT.
- stall_hazard = (state==FULL) & (hazard | nocredit).
- EMPTY: if_valid loads the slot and moves to FULL.
- FULL, on fire:
  - dec_is_jump → JWAIT, slot cleared.
  - otherwise, if_valid → reload the slot and stay in FULL (back-to-back issue, one per cycle).
  - otherwise → EMPTY.
- FULL, without fire: slot holds and is stable.
- JWAIT: only redirect_valid moves to EMPTY. fetch input is ignored.
- redirect_valid in any state: slot discarded, next state EMPTY. It overrides fire and if_valid in the same cycle.
- Scoreboard:
  - Load fire with ra_d != 0 sets bit[ra_d].
  - wb_valid clears bit[wb_rd]; wb_rd = 0 is ignored.
  - If set and clear hit the same index in one cycle, set wins.
  - Register 0 is never set.
  - redirect does not clear the scoreboard; outstanding loads still complete.
- load_cnt:
  - +1 on load fire, −1 on wb_valid, unchanged if both occur.
  - wb_valid with load_cnt == 0 is ignored (saturating at 0).
- Issue latency: an instruction accepted in cycle N can fire in N+1 at the earliest.
- A reset asserted mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro: ISSUE_STALL_CNT_EN.
- Defined: adds outputs hazard_cycles [CNT_W-1:0] and jump_cycles [CNT_W-1:0].
  - hazard_cycles increments each cycle stall_hazard = 1.
  - jump_cycles increments each cycle in JWAIT.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package mollusc_pkg: issue-state enum (EMPTY, FULL, JWAIT), NUM_REGS = 16, REG_ZERO = 4'h0, INSTR_W = 27.
- Sub-module issue_scoreboard contains:
  - 16-bit pending vector with set/clear ports and set-wins rule;
  - four lookup ports returning busy, with index 0 always 0.

Test Plan:
- Back-to-back ALU ops with ra_a = 3, ra_b = 4, ra_d = 5, and if_valid plus iss_ready held 1 → one fire per cycle, if_ready stays 1, scoreboard stays 0.
- Load issues with ra_d = 5; next instruction has ra_a = 5 → iss_valid = 0, stall_hazard = 1 until wb_valid with wb_rd = 5; fires the following cycle.
- MAX_LOADS = 4: issue four loads to r1..r4, then a fifth load to r6 → fifth is blocked with stall_hazard = 1. A single wb_valid with wb_rd = 1 lets it fire; load_cnt returns to 4.
- Jump fires → state JWAIT, if_ready = 0 for 3 cycles while if_valid = 1; redirect_valid → EMPTY, then the next if_valid is accepted.
- Load fire setting r7 in the same cycle as wb_valid with wb_rd = 7 → bit 7 remains set and load_cnt is unchanged.
- redirect_valid in FULL with iss_ready = 1 and no hazard → no fire, slot discarded, state EMPTY. Assert rst_n low mid-stall → all outputs at reset values within the same cycle.
